// File: rtl/stopwatch_pkg.sv
// Shared widths, state encoding and defaults for the stopwatch controller.
package stopwatch_pkg;

    localparam int unsigned NUM_DIGITS       = 4;
    localparam int unsigned DIGIT_W          = 4;
    localparam int unsigned DISP_W           = NUM_DIGITS * DIGIT_W;
    localparam int unsigned TICK_DIV_DEFAULT = 10;
    localparam int unsigned PRESC_W          = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_LAP   = 2'd3
    } state_t;

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade: increments on enable, wraps 9 -> 0, carries out when rolling over.
module bcd_digit
    import stopwatch_pkg::*;
(
    input  logic               clk,
    input  logic               rstn,
    input  logic               i_en,
    input  logic               i_clr,
    output logic [DIGIT_W-1:0] o_val,
    output logic               o_carry_c
);

    logic [DIGIT_W-1:0] r_val;

    // Decade counter; synchronous clear wins over enable.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_val <= '0;
        end else if (i_clr) begin
            r_val <= '0;
        end else if (i_en) begin
            r_val <= (r_val == DIGIT_W'(9)) ? '0 : r_val + DIGIT_W'(1);
        end
    end

    assign o_val     = r_val;
    assign o_carry_c = i_en && (r_val == DIGIT_W'(9));

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: run/pause/lap FSM, tick prescaler, four-decade BCD count, lap freeze.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start_stop,
    input  logic              clear,
    input  logic              lap,
    output logic [DISP_W-1:0] disp,
    output logic              running,
    output logic              ovf
);

    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_lap_cap;
    logic                w_active;
    logic                w_tick;
    logic [PRESC_W-1:0]  r_presc;
    logic [DISP_W-1:0]   r_lap;
    logic                r_ovf;
    logic [DISP_W-1:0]   w_count;
    logic [NUM_DIGITS:0] w_en;

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state with clear > start_stop > lap; lap capture only from RUN.
    always_comb begin
        w_state_nxt = r_state;
        w_lap_cap   = 1'b0;
        if (clear) begin
            w_state_nxt = ST_IDLE;
        end else if (start_stop) begin
            case (r_state)
                ST_IDLE:  w_state_nxt = ST_RUN;
                ST_RUN:   w_state_nxt = ST_PAUSE;
                ST_LAP:   w_state_nxt = ST_PAUSE;
                ST_PAUSE: w_state_nxt = ST_RUN;
                default:  w_state_nxt = ST_IDLE;
            endcase
        end else if (lap) begin
            case (r_state)
                ST_RUN: begin
                    w_state_nxt = ST_LAP;
                    w_lap_cap   = 1'b1;
                end
                ST_LAP:  w_state_nxt = ST_RUN;
                default: w_state_nxt = r_state;
            endcase
        end
    end

    assign w_active = (r_state == ST_RUN) || (r_state == ST_LAP);
    assign w_tick   = w_active && (r_presc == PRESC_MAX);

    // Prescaler: counts while active, holds in PAUSE, zero in IDLE or on clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_presc <= '0;
        end else if (clear || (r_state == ST_IDLE)) begin
            r_presc <= '0;
        end else if (w_active) begin
            r_presc <= w_tick ? '0 : r_presc + PRESC_W'(1);
        end
    end

    // Four chained decades; each carry enables the next one up.
    assign w_en[0] = w_tick;
    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
        bcd_digit u_digit (
            .clk       (clk),
            .rstn      (rstn),
            .i_en      (w_en[k]),
            .i_clr     (clear),
            .o_val     (w_count[k*DIGIT_W +: DIGIT_W]),
            .o_carry_c (w_en[k+1])
        );
    end

    // Lap register holds the live count sampled on entry to LAP.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_lap <= '0;
        end else if (clear) begin
            r_lap <= '0;
        end else if (w_lap_cap) begin
            r_lap <= w_count;
        end
    end

    // Sticky overflow, set when the top decade rolls over.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ovf <= 1'b0;
        end else if (clear) begin
            r_ovf <= 1'b0;
        end else if (w_en[NUM_DIGITS]) begin
            r_ovf <= 1'b1;
        end
    end

    assign disp    = (r_state == ST_LAP) ? r_lap : w_count;
    assign running = w_active;
    assign ovf     = r_ovf;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: TICK_DIV=4 instance (a) and TICK_DIV=1 instance (b).
module tb_stopwatch_ctrl;

    typedef struct {
        string       name;
        bit          dut_b;
        logic [15:0] disp;
        logic        running;
        logic        ovf;
    } exp_t;

    logic        clk;
    logic        rstn;
    logic        ss_a, clr_a, lap_a;
    logic        ss_b, clr_b, lap_b;
    logic [15:0] disp_a, disp_b;
    logic        run_a, run_b;
    logic        ovf_a, ovf_b;

    exp_t        q[$];
    exp_t        m_e;
    logic [15:0] m_disp;
    logic        m_run;
    logic        m_ovf;
    bit          m_ok;
    int          n_pass;
    int          n_total;

    stopwatch_ctrl #(.TICK_DIV(4)) u_dut_a (
        .clk        (clk),
        .rstn       (rstn),
        .start_stop (ss_a),
        .clear      (clr_a),
        .lap        (lap_a),
        .disp       (disp_a),
        .running    (run_a),
        .ovf        (ovf_a)
    );

    stopwatch_ctrl #(.TICK_DIV(1)) u_dut_b (
        .clk        (clk),
        .rstn       (rstn),
        .start_stop (ss_b),
        .clear      (clr_b),
        .lap        (lap_b),
        .disp       (disp_b),
        .running    (run_b),
        .ovf        (ovf_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not finish, checks so far %0d/%0d", n_pass, n_total);
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_exp(input string name, input bit dut_b, input logic [15:0] d,
                            input logic r, input logic o);
        exp_t e;
        e.name    = name;
        e.dut_b   = dut_b;
        e.disp    = d;
        e.running = r;
        e.ovf     = o;
        q.push_back(e);
    endtask

    // Monitor: on each falling edge, compare every pending expectation with the DUT outputs.
    always @(negedge clk) begin
        while (q.size() > 0) begin
            m_e    = q.pop_front();
            m_disp = m_e.dut_b ? disp_b : disp_a;
            m_run  = m_e.dut_b ? run_b  : run_a;
            m_ovf  = m_e.dut_b ? ovf_b  : ovf_a;
            m_ok   = 1'b1;
            n_total++;
            if (m_disp !== m_e.disp) begin
                m_ok = 1'b0;
            end
            if (m_run !== m_e.running) begin
                m_ok = 1'b0;
            end
            if (m_ovf !== m_e.ovf) begin
                m_ok = 1'b0;
            end
            if (m_ok) begin
                n_pass++;
            end else begin
                $display("FAIL %s: got disp=%h running=%b ovf=%b, want disp=%h running=%b ovf=%b",
                         m_e.name, m_disp, m_run, m_ovf, m_e.disp, m_e.running, m_e.ovf);
            end
        end
    end

    initial begin
        n_pass  = 0;
        n_total = 0;
        rstn    = 1'b0;
        ss_a = 1'b0; clr_a = 1'b0; lap_a = 1'b0;
        ss_b = 1'b0; clr_b = 1'b0; lap_b = 1'b0;

        // Reset state of both instances
        push_exp("reset_a", 1'b0, 16'h0000, 1'b0, 1'b0);
        push_exp("reset_b", 1'b1, 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        rstn = 1'b1;
        step(1);

        // Count from start: carry 0009 -> 0010 on the 40th edge, 0012 after 48
        ss_a = 1'b1; step(1); ss_a = 1'b0;
        push_exp("run_entry", 1'b0, 16'h0000, 1'b1, 1'b0);
        step(39);
        push_exp("pre_carry_39", 1'b0, 16'h0009, 1'b1, 1'b0);
        step(1);
        push_exp("carry_40", 1'b0, 16'h0010, 1'b1, 1'b0);
        step(8);
        push_exp("run_48", 1'b0, 16'h0012, 1'b1, 1'b0);
        clr_a = 1'b1; step(1); clr_a = 1'b0;
        push_exp("clear_from_run", 1'b0, 16'h0000, 1'b0, 1'b0);

        // Pause at 0003 (prescaler left at 1), hold, lap ignored, resume with 3 remaining cycles
        ss_a = 1'b1; step(1); ss_a = 1'b0;
        step(12);
        push_exp("at_0003", 1'b0, 16'h0003, 1'b1, 1'b0);
        ss_a = 1'b1; step(1); ss_a = 1'b0;
        push_exp("pause_enter", 1'b0, 16'h0003, 1'b0, 1'b0);
        step(10);
        lap_a = 1'b1; step(1); lap_a = 1'b0;
        push_exp("pause_lap_ignored", 1'b0, 16'h0003, 1'b0, 1'b0);
        step(9);
        push_exp("pause_hold_20", 1'b0, 16'h0003, 1'b0, 1'b0);
        ss_a = 1'b1; step(1); ss_a = 1'b0;
        push_exp("resume", 1'b0, 16'h0003, 1'b1, 1'b0);
        step(2);
        push_exp("resume_no_tick_yet", 1'b0, 16'h0003, 1'b1, 1'b0);
        step(1);
        push_exp("resume_partial_tick", 1'b0, 16'h0004, 1'b1, 1'b0);
        clr_a = 1'b1; step(1); clr_a = 1'b0;
        push_exp("clear_after_resume", 1'b0, 16'h0000, 1'b0, 1'b0);

        // Lap freeze at 0005 while counting continues underneath
        ss_a = 1'b1; step(1); ss_a = 1'b0;
        step(20);
        push_exp("lap_pre", 1'b0, 16'h0005, 1'b1, 1'b0);
        lap_a = 1'b1; step(1); lap_a = 1'b0;
        push_exp("lap_enter", 1'b0, 16'h0005, 1'b1, 1'b0);
        step(32);
        push_exp("lap_frozen_32", 1'b0, 16'h0005, 1'b1, 1'b0);
        lap_a = 1'b1; step(1); lap_a = 1'b0;
        push_exp("lap_release", 1'b0, 16'h0013, 1'b1, 1'b0);

        // start_stop beats lap in the same cycle: PAUSE, not LAP
        ss_a = 1'b1; lap_a = 1'b1; step(1); ss_a = 1'b0; lap_a = 1'b0;
        push_exp("prio_ss_over_lap", 1'b0, 16'h0013, 1'b0, 1'b0);
        step(3);
        push_exp("prio_pause_hold", 1'b0, 16'h0013, 1'b0, 1'b0);
        ss_a = 1'b1; step(1); ss_a = 1'b0;
        push_exp("rerun", 1'b0, 16'h0013, 1'b1, 1'b0);

        // clear beats start_stop in the same cycle
        ss_a = 1'b1; clr_a = 1'b1; step(1); ss_a = 1'b0; clr_a = 1'b0;
        push_exp("prio_clear_over_ss", 1'b0, 16'h0000, 1'b0, 1'b0);
        step(4);
        push_exp("idle_stays", 1'b0, 16'h0000, 1'b0, 1'b0);
        lap_a = 1'b1; step(1); lap_a = 1'b0;
        push_exp("idle_lap_ignored", 1'b0, 16'h0000, 1'b0, 1'b0);

        // Asynchronous reset mid-run at 0007, then wait in IDLE
        ss_a = 1'b1; step(1); ss_a = 1'b0;
        step(28);
        push_exp("pre_reset_0007", 1'b0, 16'h0007, 1'b1, 1'b0);
        @(negedge clk);
        #1;
        rstn = 1'b0;
        #1;
        n_total++;
        if (disp_a === 16'h0000 && run_a === 1'b0 && ovf_a === 1'b0) begin
            n_pass++;
        end else begin
            $display("FAIL async_reset_immediate: got disp=%h running=%b ovf=%b",
                     disp_a, run_a, ovf_a);
        end
        push_exp("async_reset", 1'b0, 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        rstn = 1'b1;
        step(8);
        push_exp("post_reset_idle", 1'b0, 16'h0000, 1'b0, 1'b0);

        // TICK_DIV=1: 10000 ticks wrap 9999 -> 0000 and set sticky ovf
        ss_b = 1'b1; step(1); ss_b = 1'b0;
        step(9999);
        push_exp("b_9999", 1'b1, 16'h9999, 1'b1, 1'b0);
        step(1);
        push_exp("b_wrap_ovf", 1'b1, 16'h0000, 1'b1, 1'b1);
        step(3);
        push_exp("b_ovf_sticky", 1'b1, 16'h0003, 1'b1, 1'b1);
        clr_b = 1'b1; step(1); clr_b = 1'b0;
        push_exp("b_clear_ovf", 1'b1, 16'h0000, 1'b0, 1'b0);
        step(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 10, clock cycles per count tick; legal range 1..65535.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rstn  input  1  reset, asynchronous, active-low.
REQ-004 start_stop  input  1  single-cycle pulse; toggles run/pause.
REQ-005 clear  input  1  single-cycle pulse; zero count, return to IDLE, clear ovf.
REQ-006 lap  input  1  single-cycle pulse; freeze/unfreeze displayed value.
REQ-007 disp  output  16  four BCD digits, [3:0] least significant.
REQ-008 running  output  1  high in RUN or LAP.
REQ-009 ovf  output  1  sticky overflow flag.

Function
REQ-010 The FSM SHALL have states IDLE, RUN, PAUSE, LAP.
REQ-011 IDLE: start_stop -> RUN; lap ignored; clear keeps IDLE, clears ovf.
REQ-012 RUN: start_stop -> PAUSE; lap -> LAP, capturing the live count into the lap register at the same edge; clear -> IDLE.
REQ-013 LAP: lap -> RUN; start_stop -> PAUSE; clear -> IDLE.
REQ-014 PAUSE: start_stop -> RUN; lap ignored; clear -> IDLE.
REQ-015 Simultaneous inputs SHALL resolve with priority clear > start_stop > lap; lower-priority pulses in that cycle are discarded.
REQ-016 The prescaler SHALL count 0..TICK_DIV-1 each cycle in RUN/LAP, wrap to 0, hold its value in PAUSE, and be 0 in IDLE.
REQ-017 tick SHALL be high for one cycle when state is RUN/LAP and prescaler == TICK_DIV-1; with TICK_DIV=1, tick is high every RUN/LAP cycle.
REQ-018 First tick after entry to RUN from IDLE SHALL update the count at the TICK_DIV-th edge after the edge that sampled start_stop.
REQ-019 Digit 0 SHALL increment on tick; digit k SHALL increment on tick when all lower digits equal 9; a digit at 9 that increments SHALL wrap to 0.
REQ-020 Count 9999 plus tick SHALL become 0000 and set ovf at the same edge; ovf stays set until clear or reset.
REQ-021 disp SHALL show the lap register in LAP and the live count in all other states, with no added latency beyond the register update.
REQ-022 Counting SHALL continue in LAP while disp is frozen.
REQ-023 Entry to IDLE via clear SHALL zero the count, the lap register and the prescaler at the same edge.

Reset
REQ-024 rstn low SHALL immediately force state IDLE, count 0000, lap register 0000, prescaler 0, disp 16'h0000, running 0, ovf 0.
REQ-025 Reset asserted mid-count SHALL abort without completing any pending tick; after release, the block waits in IDLE for start_stop.

Structure
REQ-026 State encodings, digit count (4) and the TICK_DIV default SHALL live in shared package stopwatch_pkg.
REQ-027 Each decade SHALL be an instance of sub-module bcd_digit (enable, synchronous clear, 4-bit value, carry = enable and value==9), chained four deep.
REQ-028 The FSM, prescaler and lap register SHALL reside in stopwatch_ctrl; no latches, no derived clocks.

Verification (TICK_DIV=4 unless stated)
REQ-029 Pulse rstn low mid-RUN at disp 0007 -> disp 0000, running 0, ovf 0 without waiting for clk.
REQ-030 start_stop, then 48 cycles -> disp 0012, running 1; digit carry 0009->0010 at the 40th cycle.
REQ-031 At disp 0003, start_stop; idle 20 cycles -> disp 0003, running 0; start_stop again -> the next tick occurs after the remaining prescaler cycles, not a full TICK_DIV.
REQ-032 lap at disp 0005; run 32 cycles -> disp 0005, running 1; lap again -> disp 0013.
REQ-033 TICK_DIV=1, run 10000 cycles from start -> disp 0000, ovf 1; clear -> ovf 0, state IDLE.
REQ-034 In RUN, clear and start_stop in the same cycle -> IDLE, disp 0000, running 0.
